// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame limits, idle line level
// and the parity helper used when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam int   UART_DATA_W_MAX = 8;
  localparam logic UART_IDLE_LVL   = 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic calc_parity(input logic [UART_DATA_W_MAX-1:0] data,
                                       input logic                       odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud.sv
// Baud generator shared by the UART receiver and transmitter: a x16 oversampling tick
// every cfg_div+1 clocks, a mid-bit strobe and an end-of-bit strobe every 16 ticks.
module uart_baud (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [15:0] cfg_div,
  input  logic        clear,
  output logic        baud_sample_mid,
  output logic        baud_sample_16th
);

  logic [15:0] div_cnt;
  logic [3:0]  sub_cnt;
  logic        tick;

  assign tick             = (div_cnt == cfg_div);
  assign baud_sample_mid  = tick & (sub_cnt == 4'd7);
  assign baud_sample_16th = tick & (sub_cnt == 4'd15);

  // Divider and sub-bit counters; clear holds both at zero so a bit starts exactly on release.
  always_ff @(posedge clk) begin
    if (!rst_b || clear) begin
      div_cnt <= 16'd0;
      sub_cnt <= 4'd0;
    end else if (tick) begin
      div_cnt <= 16'd0;
      sub_cnt <= sub_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
      sub_cnt <= sub_cnt;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, start + DATA_W bits LSb first + 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the cfg_parity_odd port and a parity bit before the stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [15:0]       cfg_div,
  input  logic              cfg_txen,
  input  logic              cfg_nstop,
`ifdef UART_TX_PARITY_EN
  input  logic              cfg_parity_odd,
`endif
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              uart_txd
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              nstop_q;
  logic              accept;
  logic              bit_end;
  logic              baud_mid_unused;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  assign tx_ready = (state == ST_IDLE) & cfg_txen;
  assign accept   = tx_valid & tx_ready;

  uart_baud u_baud (
    .clk              (clk),
    .rst_b            (rst_b),
    .cfg_div          (cfg_div),
    .clear            (state == ST_IDLE),
    .baud_sample_mid  (baud_mid_unused),
    .baud_sample_16th (bit_end)
  );

  // Frame sequencer: the line is registered and always takes the value of the bit being entered.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      nstop_q  <= 1'b0;
      tx_busy  <= 1'b0;
      uart_txd <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          if (accept) begin
            shreg    <= tx_data;
            nstop_q  <= cfg_nstop;
            state    <= ST_START;
            tx_busy  <= 1'b1;
            uart_txd <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= calc_parity(UART_DATA_W_MAX'(tx_data), cfg_parity_odd);
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            uart_txd <= shreg[0];
            shreg    <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state    <= ST_PARITY;
              uart_txd <= par_q;
`else
              state    <= ST_STOP;
              uart_txd <= UART_IDLE_LVL;
`endif
            end else begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              uart_txd <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            uart_txd <= UART_IDLE_LVL;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt == nstop_q) begin
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_busy  <= 1'b0;
          uart_txd <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule
